// File: rtl/wshb_arb_pkg.sv
// Shared definitions for the two-requester Wishbone arbiter:
// FSM state encodings, requester indices and a small helper.
package wshb_arb_pkg;

    // FSM state encodings (IDLE, OWN, DRAIN)
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_OWN   = 2'd1;
    localparam arb_state_t ST_DRAIN = 2'd2;

    // Requester indices: test-pattern generator and VGA frame reader
    localparam logic REQ_MIRE = 1'b0;
    localparam logic REQ_VGA  = 1'b1;

    // With two requesters, "the other one" is simply the inverted index
    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/wshb_arb_outst.sv
// Outstanding-request counter and per-grant burst counter for the
// Wishbone arbiter. The outstanding count tracks accepted-but-unanswered
// strobes; the burst count tracks strobes accepted under the current grant
// and wraps to zero after MAX_BURST accepts.
module wshb_arb_outst
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 64,
    parameter int MAX_OUTST = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_clr_burst,
    input  logic                             i_accept,
    input  logic                             i_resp,
    output logic [$clog2(MAX_OUTST+1)-1:0]   o_outst,
    output logic [$clog2(MAX_OUTST+1)-1:0]   o_outst_next,
    output logic                             o_outst_full,
    output logic                             o_burst_last
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [OW-1:0] r_outst;
    logic [BW-1:0] r_burst;
    logic [OW-1:0] w_outst_next;

    // Next outstanding count: an accept and a response in the same cycle cancel;
    // a response with nothing outstanding is ignored rather than underflowing.
    always_comb begin
        w_outst_next = r_outst;
        if (i_accept && !i_resp) begin
            w_outst_next = r_outst + OW'(1);
        end else if (!i_accept && i_resp && (r_outst != '0)) begin
            w_outst_next = r_outst - OW'(1);
        end
    end

    // Outstanding counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outst <= '0;
        end else begin
            r_outst <= w_outst_next;
        end
    end

    // Burst counter: cleared while not owning, wraps after the last allowed accept
    always_ff @(posedge clk) begin
        if (rst || i_clr_burst) begin
            r_burst <= '0;
        end else if (i_accept) begin
            if (o_burst_last) begin
                r_burst <= '0;
            end else begin
                r_burst <= r_burst + BW'(1);
            end
        end
    end

    assign o_outst      = r_outst;
    assign o_outst_next = w_outst_next;
    assign o_outst_full = (r_outst == OW'(MAX_OUTST));
    assign o_burst_last = (r_burst == BW'(MAX_BURST - 1));

endmodule

// File: rtl/wshb_arbiter.sv
// Two-requester pipelined Wishbone arbiter sharing one SDRAM-side master
// port between the pattern generator (requester 0) and the VGA reader
// (requester 1). Ownership changes only once the bus has drained.
// Optional build macro WSHB_ARBITER_VGA_PRIO_EN: fixed VGA priority, VGA
// pre-empts a mire burst immediately; otherwise round-robin with both
// requesters capped at MAX_BURST accepts per grant.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 64,
    parameter int MAX_OUTST = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       m_cyc,
    input  logic [1:0]       m_stb,
    input  logic [1:0]       m_we,
    input  logic [1:0][31:0] m_adr,
    input  logic [1:0][31:0] m_dat_w,
    input  logic [1:0][3:0]  m_sel,
    output logic [31:0]      m_dat_r,
    output logic [1:0]       m_ack,
    output logic [1:0]       m_err,
    output logic [1:0]       m_stall,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [31:0]      s_adr,
    output logic [31:0]      s_dat_w,
    output logic [3:0]       s_sel,
    input  logic [31:0]      s_dat_r,
    input  logic             s_ack,
    input  logic             s_err,
    input  logic             s_stall,
    output logic             owner,
    output logic             busy
);

    localparam int OW = $clog2(MAX_OUTST + 1);

`ifdef WSHB_ARBITER_VGA_PRIO_EN
    localparam logic VGA_PRIO = 1'b1;
`else
    localparam logic VGA_PRIO = 1'b0;
`endif

    // Handshake: a strobe is accepted in any cycle where s_stb=1 and s_stall=0;
    // each accepted strobe is answered by exactly one s_ack or s_err cycle.

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_owner;
    logic       r_last_owner;

    logic          w_own;
    logic          w_drain;
    logic          w_active;
    logic          w_other;
    logic          w_grant;
    logic          w_accept;
    logic          w_resp;
    logic          w_cap_en;
    logic          w_burst_hit;
    logic          w_preempt;
    logic [OW-1:0] w_outst;
    logic [OW-1:0] w_outst_next;
    logic          w_outst_full;
    logic          w_burst_last;

    assign w_own    = (r_state == ST_OWN);
    assign w_drain  = (r_state == ST_DRAIN);
    assign w_active = w_own || w_drain;
    assign w_other  = other_req(r_owner);

    // Responses only count while someone owns the bus; stray ones after reset are dropped
    assign w_accept = s_stb && !s_stall;
    assign w_resp   = w_active && (s_ack || s_err);

    // Under VGA priority only the mire is capped; otherwise both are
    assign w_cap_en    = VGA_PRIO ? (r_owner == REQ_MIRE) : 1'b1;
    assign w_burst_hit = w_accept && w_burst_last && w_cap_en && m_cyc[w_other];
    assign w_preempt   = VGA_PRIO && (r_owner == REQ_MIRE) && m_cyc[REQ_VGA];

    // Tie-break: VGA under priority, else whoever did not own last time
    always_comb begin
        w_grant = REQ_MIRE;
        if (m_cyc == 2'b11) begin
            w_grant = VGA_PRIO ? REQ_VGA : other_req(r_last_owner);
        end else if (m_cyc[REQ_VGA]) begin
            w_grant = REQ_VGA;
        end
    end

    wshb_arb_outst #(
        .MAX_BURST (MAX_BURST),
        .MAX_OUTST (MAX_OUTST)
    ) u_outst (
        .clk          (clk),
        .rst          (rst),
        .i_clr_burst  (!w_own),
        .i_accept     (w_accept),
        .i_resp       (w_resp),
        .o_outst      (w_outst),
        .o_outst_next (w_outst_next),
        .o_outst_full (w_outst_full),
        .o_burst_last (w_burst_last)
    );

    // Next-state logic: grant in IDLE, release on drop/cap/pre-empt, drain to zero
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m_cyc != 2'b00) begin
                    w_state_next = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!m_cyc[r_owner] || w_preempt || w_burst_hit) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_outst_next == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, owner and round-robin history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= REQ_MIRE;
            r_last_owner <= REQ_VGA;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && (m_cyc != 2'b00)) begin
                r_owner      <= w_grant;
                r_last_owner <= w_grant;
            end
        end
    end

    // Combinational routing between the owner and the slave port
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        m_stall = 2'b11;
        m_ack   = 2'b00;
        m_err   = 2'b00;
        if (w_own) begin
            s_cyc            = m_cyc[r_owner];
            s_stb            = m_cyc[r_owner] && m_stb[r_owner] && !w_outst_full;
            s_we             = m_we[r_owner];
            s_adr            = m_adr[r_owner];
            s_dat_w          = m_dat_w[r_owner];
            s_sel            = m_sel[r_owner];
            m_stall[r_owner] = s_stall || w_outst_full;
        end else if (w_drain) begin
            s_cyc = (w_outst != '0);
        end
        if (w_active) begin
            m_ack[r_owner] = s_ack;
            m_err[r_owner] = s_err;
        end
    end

    assign m_dat_r = s_dat_r;
    assign owner   = r_owner;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed-vector bench for wshb_arbiter (MAX_BURST=4, MAX_OUTST=8).
// Each vector gives one cycle's inputs and the outputs expected in that cycle.
module tb_wshb_arbiter;

    localparam logic [31:0] ADR0 = 32'h0000_1000;
    localparam logic [31:0] ADR1 = 32'h0000_2000;
    localparam logic [31:0] DAT0 = 32'h1111_1111;
    localparam logic [31:0] DAT1 = 32'h2222_2222;
    localparam logic [3:0]  SEL0 = 4'h3;
    localparam logic [3:0]  SEL1 = 4'hC;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       m_cyc = '0;
    logic [1:0]       m_stb = '0;
    logic [1:0]       m_we;
    logic [1:0][31:0] m_adr;
    logic [1:0][31:0] m_dat_w;
    logic [1:0][3:0]  m_sel;
    logic [31:0]      m_dat_r;
    logic [1:0]       m_ack, m_err, m_stall;
    logic             s_cyc, s_stb, s_we;
    logic [31:0]      s_adr, s_dat_w;
    logic [3:0]       s_sel;
    logic [31:0]      s_dat_r = '0;
    logic             s_ack = 1'b0;
    logic             s_err = 1'b0;
    logic             s_stall = 1'b0;
    logic             owner, busy;

    wshb_arbiter #(.MAX_BURST(4), .MAX_OUTST(8)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r),
        .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
        .owner(owner), .busy(busy)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] cyc, stb;
        logic       ack, err, stall;
        logic       e_scyc, e_sstb;
        logic [1:0] e_stall, e_ack, e_err;
        logic       e_busy, e_owner;
    } vec_t;

    vec_t vq[$];

    // ---------------- driver tasks ----------------
    task automatic add(input logic r, input logic [1:0] cyc, input logic [1:0] stb,
                       input logic ack, input logic err, input logic stall,
                       input logic e_scyc, input logic e_sstb, input logic [1:0] e_stall,
                       input logic [1:0] e_ack, input logic [1:0] e_err,
                       input logic e_busy, input logic e_owner);
        vec_t v;
        v.rst = r; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.stall = stall;
        v.e_scyc = e_scyc; v.e_sstb = e_sstb; v.e_stall = e_stall;
        v.e_ack = e_ack; v.e_err = e_err; v.e_busy = e_busy; v.e_owner = e_owner;
        vq.push_back(v);
    endtask

    task automatic run_vecs(input string name);
        vec_t v;
        logic [31:0] rd;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(posedge clk);
            #1;
            rd      = 32'hC0DE_0000 + 32'(i);
            rst     = v.rst;
            m_cyc   = v.cyc;
            m_stb   = v.stb;
            s_ack   = v.ack;
            s_err   = v.err;
            s_stall = v.stall;
            s_dat_r = rd;
            #1;
            chk($sformatf("%s%0d.s_cyc", name, i), 32'(s_cyc), 32'(v.e_scyc));
            chk($sformatf("%s%0d.s_stb", name, i), 32'(s_stb), 32'(v.e_sstb));
            chk($sformatf("%s%0d.m_stall", name, i), 32'(m_stall), 32'(v.e_stall));
            chk($sformatf("%s%0d.m_ack", name, i), 32'(m_ack), 32'(v.e_ack));
            chk($sformatf("%s%0d.m_err", name, i), 32'(m_err), 32'(v.e_err));
            chk($sformatf("%s%0d.busy", name, i), 32'(busy), 32'(v.e_busy));
            chk($sformatf("%s%0d.m_dat_r", name, i), m_dat_r, rd);
            if (v.e_busy || v.rst) begin
                chk($sformatf("%s%0d.owner", name, i), 32'(owner), 32'(v.e_owner));
            end
            if (v.e_sstb) begin
                chk($sformatf("%s%0d.s_adr", name, i), s_adr, v.e_owner ? ADR1 : ADR0);
                chk($sformatf("%s%0d.s_dat_w", name, i), s_dat_w, v.e_owner ? DAT1 : DAT0);
                chk($sformatf("%s%0d.s_sel", name, i), 32'(s_sel), 32'(v.e_owner ? SEL1 : SEL0));
                chk($sformatf("%s%0d.s_we", name, i), 32'(s_we), 32'(v.e_owner ? 1'b0 : 1'b1));
            end
            if (!v.e_busy) begin
                chk($sformatf("%s%0d.idle_fields", name, i),
                    s_adr | s_dat_w | 32'(s_sel) | 32'(s_we), 32'h0);
            end
        end
        vq.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_we    = 2'b01;
        m_adr   = {ADR1, ADR0};
        m_dat_w = {DAT1, DAT0};
        m_sel   = {SEL1, SEL0};

        // Reset, then requester 0 does 4 writes with acks one cycle later
        add(1, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 1, 0);
        add(0, 2'b01, 2'b01, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b01, 2'b01, 1, 0, 1,  1, 1, 2'b11, 2'b01, 2'b00, 1, 0);
        add(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 1, 0);
        add(0, 2'b01, 2'b01, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b00, 2'b00, 1, 0, 0,  0, 0, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
        add(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        run_vecs("wr");

`ifdef WSHB_ARBITER_VGA_PRIO_EN
        // Tie after reset goes to VGA; VGA pre-empts a mire burst at burst_cnt=2
        add(1, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b00, 0, 0, 0,  1, 0, 2'b01, 2'b00, 2'b00, 1, 1);
        add(0, 2'b01, 2'b00, 0, 0, 0,  0, 0, 2'b01, 2'b00, 2'b00, 1, 1);
        add(0, 2'b01, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 1, 1);
        add(0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 1, 0);
        add(0, 2'b01, 2'b01, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b11, 2'b01, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b11, 2'b01, 1, 0, 0,  1, 0, 2'b11, 2'b01, 2'b00, 1, 0);
        add(0, 2'b11, 2'b01, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b01, 0, 0, 0,  1, 0, 2'b01, 2'b00, 2'b00, 1, 1);
        add(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b01, 2'b00, 2'b00, 1, 1);
        add(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 1, 1);
        add(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        run_vecs("prio");
`else
        // Tie after reset goes to requester 0, then requester 1 (err response)
        add(1, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 1, 0);
        add(0, 2'b11, 2'b00, 1, 0, 0,  1, 0, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b10, 2'b00, 0, 0, 0,  0, 0, 2'b10, 2'b00, 2'b00, 1, 0);
        add(0, 2'b10, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
        add(0, 2'b10, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b10, 2'b10, 0, 0, 0,  1, 1, 2'b01, 2'b00, 2'b00, 1, 1);
        add(0, 2'b10, 2'b00, 0, 1, 0,  1, 0, 2'b01, 2'b00, 2'b10, 1, 1);
        add(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b01, 2'b00, 2'b00, 1, 1);
        add(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 1, 1);
        add(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 1);
        run_vecs("rr");

        // Burst cap of 4 while requester 1 waits, then handover to requester 1
        add(0, 2'b11, 2'b01, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 1, 0);
        add(0, 2'b11, 2'b01, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b11, 2'b01, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b11, 2'b01, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b11, 2'b01, 1, 0, 0,  1, 0, 2'b11, 2'b01, 2'b00, 1, 0);
        add(0, 2'b11, 2'b01, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b01, 0, 0, 0,  1, 0, 2'b01, 2'b00, 2'b00, 1, 1);
        add(0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 2'b01, 2'b00, 2'b00, 1, 1);
        add(0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 1, 1);
        add(0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        run_vecs("burst");
`endif

        // Slave withholds acks: 8 accepts, then stall until an ack frees a slot
        add(0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, 2'b01, 2'b01, 0, 0, 0,  1, 1, 2'b10, 2'b00, 2'b00, 1, 0);
        end
        add(0, 2'b01, 2'b01, 0, 0, 0,  1, 0, 2'b11, 2'b00, 2'b00, 1, 0);
        add(0, 2'b01, 2'b01, 0, 0, 0,  1, 0, 2'b11, 2'b00, 2'b00, 1, 0);
        add(0, 2'b01, 2'b01, 1, 0, 0,  1, 0, 2'b11, 2'b01, 2'b00, 1, 0);
        add(0, 2'b01, 2'b01, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        for (int k = 0; k < 4; k++) begin
            add(0, 2'b01, 2'b00, 1, 0, 0,  1, 0, 2'b10, 2'b01, 2'b00, 1, 0);
        end
        run_vecs("outst");

        // Reset with 3 outstanding; later acks must not reach any requester
        add(1, 2'b01, 2'b01, 1, 0, 0,  1, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        add(0, 2'b00, 2'b00, 1, 0, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b00, 2'b00, 1, 1, 0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        run_vecs("rst");

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter.md
# wshb_arbiter

Two-requester Wishbone (pipelined, B4) arbiter that shares the single SDRAM-side Wishbone master port between the test-pattern generator (requester 0, "mire") and the VGA frame reader (requester 1, "vga"). It tracks outstanding transactions, caps how long one requester can hold the bus, and switches ownership only when the bus is quiescent. It sits between the video sources and the SDRAM controller port.

## Interface
Parameters:
- MAX_BURST, 64: maximum accepted strobes per grant before forced release (≥1).
- MAX_OUTST, 8: maximum outstanding (accepted, un-acked) requests tracked; counter width is $clog2(MAX_OUTST+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset rst, synchronous, active-high.
- m_cyc  in  [1:0]  per-requester cyc, index = requester.
- m_stb  in  [1:0]  per-requester stb.
- m_we  in  [1:0]  per-requester write enable.
- m_adr  in  [1:0][31:0]  per-requester byte address.
- m_dat_w  in  [1:0][31:0]  per-requester write data.
- m_sel  in  [1:0][3:0]  per-requester byte select.
- m_dat_r  out  32  read data, broadcast to both requesters.
- m_ack  out  [1:0]  ack, routed to the owner only.
- m_err  out  [1:0]  err, routed to the owner only.
- m_stall  out  [1:0]  stall; 1 for every non-owner.
- s_cyc, s_stb, s_we  out  1  slave-side control.
- s_adr  out  32, s_dat_w  out  32, s_sel  out  4  slave-side request fields.
- s_dat_r  in  32, s_ack  in  1, s_err  in  1, s_stall  in  1  slave-side response.
- owner  out  1  current owner index, valid when busy=1.
- busy  out  1  a requester currently owns the bus.

## Operation
- FSM states: IDLE, OWN, DRAIN.
- IDLE: no owner; s_cyc=0; all m_stall=1. When any m_cyc=1, register owner per arbitration policy and go to OWN.
- OWN: owner's cyc/stb/we/adr/dat/sel pass combinationally to s_*; s_stall passes to m_stall[owner]; s_ack/s_err pass to m_ack/m_err[owner].
- Accepted strobe = s_stb & ~s_stall; increments outst and burst_cnt. s_ack or s_err decrements outst; accept and ack in the same cycle leaves outst unchanged.
- outst == MAX_OUTST: stall forced to owner, s_stb forced 0.
- burst_cnt reaching MAX_BURST and other requester's m_cyc=1: go to DRAIN. If the other requester is idle, burst_cnt restarts at 0 and the owner keeps the bus.
- Owner drops m_cyc in OWN: go to DRAIN (outst ≠ 0 is a protocol error by the owner; the arbiter still drains).
- DRAIN: s_stb=0, owner stalled, s_cyc held 1 while outst>0. At outst==0 (ack counted), go to IDLE; owner's acks/errs still routed.
- Round-robin policy: on simultaneous requests in IDLE, grant goes to the requester that did not own last; after reset, last owner = 1, so requester 0 wins the first tie.
- s_err terminates like ack; the arbiter does not abort the burst.
- rst mid-transfer: all state cleared next edge; in-flight responses after reset are discarded (outst=0, IDLE).

## Timing
- Reset values: s_cyc=0, s_stb=0, s_we=0, s_adr=0, s_dat_w=0, s_sel=0, m_ack=0, m_err=0, m_stall=2'b11, busy=0, owner=0, m_dat_r=s_dat_r.
- Grant latency: m_cyc rising in IDLE → s_cyc=1 on the next cycle (1-cycle arbitration).
- Handover: last ack in DRAIN at cycle N → IDLE at N+1 → new owner on s_cyc at N+2.
- Data/control paths owner→slave are combinational; only state, owner, outst, burst_cnt are registered.

## Configuration
- WSHB_ARBITER_VGA_PRIO_EN defined: fixed priority, requester 1 (VGA) wins every tie and its m_cyc during a mire burst forces DRAIN immediately rather than at MAX_BURST; mire keeps MAX_BURST cap.
- Undefined: round-robin as in Operation, both requesters capped by MAX_BURST.

## Structure
- Shared package wshb_arb_pkg: state enum (IDLE, OWN, DRAIN), requester index constants REQ_MIRE=0, REQ_VGA=1.
- One sub-module: wshb_arb_outst, the outstanding/burst counter pair with saturation flags.

## Test plan
- Single requester 0, 4 writes, slave acks 1 cycle later → 4 s_stb accepts, 4 m_ack[0], busy drops 2 cycles after last ack.
- Both m_cyc rise same cycle after reset → owner=0 first; after release, owner=1 without re-request gap > 2 cycles.
- MAX_BURST=4, requester 0 streams 10 reads while requester 1 waits → after 4th accept s_stb=0, DRAIN until outst=0, then owner=1.
- Slave withholds acks, MAX_OUTST=8 → 8 accepts then m_stall[0]=1, no 9th s_stb until an ack.
- Assert rst with outst=3 → next cycle s_cyc=0, busy=0, m_stall=2'b11; later s_ack produces no m_ack.
- With WSHB_ARBITER_VGA_PRIO_EN, requester 1 asserts m_cyc during mire burst at burst_cnt=2 → DRAIN immediately, VGA owns after drain.
